// File: rtl/cpu_pkg.sv
// Shared types and constants for the single-cycle MIPS core.
// Holds fetch FSM encoding, opcode values and the default reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Next-PC target computation and priority select.
// Purely combinational; flags word-misaligned targets.
module next_pc_logic
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] imm,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic        jal,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic        take_br;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign take_br = (branch_eq & zero) | (branch_ne & ~zero);
  assign br_off  = {{14{imm[15]}}, imm[15:0], 2'b00};
  assign br_tgt  = pc_plus4 + br_off;
  assign j_tgt   = {pc_plus4[31:28], imm, 2'b00};

  // jr outranks jal outranks a taken branch
  always_comb begin
    next_pc = pc_plus4;
    priority case (1'b1)
      jr:      next_pc = jr_target;
      jal:     next_pc = j_tgt;
      take_br: next_pc = br_tgt;
      default: next_pc = pc_plus4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with imem,
// holds the word until retire, then steps to the selected next PC.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              retire,
  input  logic              branch_eq,
  input  logic              branch_ne,
  input  logic              zero,
  input  logic              jal,
  input  logic              jr,
  input  logic [31:0]       jr_target,
  output logic              fault
);

  fetch_state_t state;
  fetch_state_t state_nx;
  logic [31:0]  next_pc;
  logic         misaligned;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  next_pc_logic u_next_pc (
    .pc_plus4   (pc_plus4),
    .imm        (instr[25:0]),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .zero       (zero),
    .jal        (jal),
    .jr         (jr),
    .jr_target  (jr_target),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH:   if (imem_ack) state_nx = EXEC;
      EXEC:    if (retire)
                 state_nx = misaligned ? FAULT : FETCH;
      FAULT:   state_nx = FAULT;
      default: state_nx = FETCH;
    endcase
  end

  // Request is suppressed while reset is held.
  always_comb begin
    imem_req = (state == FETCH) & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      unique case (state)
        FETCH: if (imem_ack) begin
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
        end
        EXEC: if (retire) begin
          instr_valid <= 1'b0;
          if (misaligned) fault <= 1'b1;
          else            pc    <= next_pc;
        end
        default: instr_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Linear step sequence with immediate assertions at each check.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        branch_eq;
  logic        branch_ne;
  logic        zero;
  logic        jal;
  logic        jr;
  logic [31:0] jr_target;
  logic        fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retire      (retire),
    .branch_eq   (branch_eq),
    .branch_ne   (branch_ne),
    .zero        (zero),
    .jal         (jal),
    .jr          (jr),
    .jr_target   (jr_target),
    .fault       (fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_ctrl();
    retire    = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    zero      = 1'b0;
    jal       = 1'b0;
    jr        = 1'b0;
    jr_target = 32'd0;
  endtask

  // zero-wait fetch from the current FETCH cycle
  task automatic fetch0(input string tag, input logic [31:0] w);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = w;
    step();
    imem_ack   = 1'b0;
    chk({tag, "_instr"}, instr, w);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic do_jr(input logic [31:0] t);
    jr        = 1'b1;
    jr_target = t;
    retire    = 1'b1;
    step();
    clr_ctrl();
  endtask

  initial begin
    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    clr_ctrl();

    // reset cycle
    step();
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_pc",    pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    reset = 1'b0;
    #1;
    chk("first_req",  {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // ADDI, sequential retire
    fetch0("addi", 32'h2008_0005);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    retire = 1'b1;
    step();
    clr_ctrl();
    chk("seq_pc",    pc, 32'h4);
    chk("seq_req",   {31'd0, imem_req}, 32'd1);
    chk("seq_valid", {31'd0, instr_valid}, 32'd0);

    // BEQ taken at 0x10
    fetch0("nop1", 32'h0);
    do_jr(32'h10);
    chk("jr10_pc", pc, 32'h10);
    fetch0("beq1", 32'h1109_FFFE);
    branch_eq = 1'b1;
    zero      = 1'b1;
    retire    = 1'b1;
    step();
    clr_ctrl();
    chk("beq_taken_pc", pc, 32'h0C);

    // BEQ not taken at 0x10
    fetch0("nop2", 32'h0);
    do_jr(32'h10);
    fetch0("beq2", 32'h1109_FFFE);
    branch_eq = 1'b1;
    zero      = 1'b0;
    retire    = 1'b1;
    step();
    clr_ctrl();
    chk("beq_nt_pc", pc, 32'h14);

    // BNE taken: 0x14+4 + (-2<<2) = 0x10
    fetch0("bne", 32'h1509_FFFE);
    branch_ne = 1'b1;
    retire    = 1'b1;
    step();
    clr_ctrl();
    chk("bne_pc", pc, 32'h10);

    // JAL at 0x20
    fetch0("nop3", 32'h0);
    do_jr(32'h20);
    fetch0("jal1", 32'h0C00_0040);
    chk("jal_pc4", pc_plus4, 32'h24);
    jal    = 1'b1;
    retire = 1'b1;
    step();
    clr_ctrl();
    chk("jal_pc", pc, 32'h100);

    // jr wins over jal
    fetch0("nop4", 32'h0);
    do_jr(32'h20);
    fetch0("jal2", 32'h0C00_0040);
    jal       = 1'b1;
    jr        = 1'b1;
    jr_target = 32'h200;
    retire    = 1'b1;
    step();
    clr_ctrl();
    chk("jr_prio_pc", pc, 32'h200);

    // three wait states, retire during FETCH ignored
    for (int i = 0; i < 3; i++) begin
      chk("ws_req",   {31'd0, imem_req}, 32'd1);
      chk("ws_addr",  imem_addr, 32'h200);
      chk("ws_valid", {31'd0, instr_valid}, 32'd0);
      retire = (i == 1);
      step();
    end
    retire     = 1'b0;
    chk("ws_pc", pc, 32'h200);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0020;
    chk("ws_ack_valid", {31'd0, instr_valid}, 32'd0);
    step();
    imem_ack = 1'b0;
    chk("ws_valid_up", {31'd0, instr_valid}, 32'd1);
    chk("ws_instr",    instr, 32'h0000_0020);

    // late ack in EXEC is ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    chk("exec_ack_instr", instr, 32'h0000_0020);

    // misaligned jr target
    do_jr(32'h1002);
    chk("flt_fault", {31'd0, fault}, 32'd1);
    chk("flt_pc",    pc, 32'h200);
    chk("flt_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    retire   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("flt_req", {31'd0, imem_req}, 32'd0);
      step();
    end
    imem_ack = 1'b0;
    retire   = 1'b0;
    chk("flt_hold", {31'd0, fault}, 32'd1);

    // reset clears fault
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rec_fault", {31'd0, fault}, 32'd0);
    chk("rec_pc",    pc, 32'h0);
    chk("rec_req",   {31'd0, imem_req}, 32'd1);

    // reset concurrent with ack discards data
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    reset      = 1'b1;
    step();
    reset    = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("rack_instr", instr, 32'h0);
    chk("rack_valid", {31'd0, instr_valid}, 32'd0);
    chk("rack_pc",    pc, 32'h0);
    chk("rack_req",   {31'd0, imem_req}, 32'd1);
    fetch0("rack_refetch", 32'h2008_0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
